// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared pixel/frame sizing and receiver state encoding.
package led_pkg;

  localparam int CDEPTH      = 4;
  localparam int FRAME_ORDER = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_pixel_rx_if.sv
// rtl/spi_pixel_rx_if.sv - pixel write bus from the SPI receiver to the frame buffer.
interface spi_pixel_rx_if #(
  parameter int CDEPTH      = 4,
  parameter int FRAME_ORDER = 10
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [FRAME_ORDER-1:0] waddr;
  logic [3*CDEPTH-1:0]    wpix;

  modport master (output wr_valid, output waddr, output wpix, input wr_ready);
  modport slave  (input wr_valid, input waddr, input wpix, output wr_ready);
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/spi_pixel_rx.sv
// rtl/spi_pixel_rx.sv - SPI pixel receiver writing LSB-first pixels into a frame buffer.
// Optional macro SPI_RX_ERR_EN enables frame_err reporting (short frame / overrun).
module spi_pixel_rx #(
  parameter int CDEPTH      = led_pkg::CDEPTH,
  parameter int FRAME_ORDER = led_pkg::FRAME_ORDER
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sck,
  input  logic           sdi,
  input  logic           cs_n,
  spi_pixel_rx_if.master wr,
  output logic           frame_done,
  output logic           frame_err
);
  import led_pkg::*;

  localparam int W  = 3 * CDEPTH;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0]          LAST_BIT = BW'(W - 1);
  localparam logic [FRAME_ORDER-1:0] ADDR_MAX = '1;
`ifdef SPI_RX_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic sck_s, sdi_s, cs_s;

  sync2 #(.RST_VAL(1'b0)) u_sync_sck (.clk(clk), .reset(reset), .d(sck),  .q(sck_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_sdi (.clk(clk), .reset(reset), .d(sdi),  .q(sdi_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs  (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s));

  rx_state_t              state_q, state_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [BW-1:0]          bitcnt_q, bitcnt_d;
  logic [W-2:0]           shreg_q, shreg_d;
  logic [W-1:0]           wpix_q, wpix_d;
  logic [FRAME_ORDER-1:0] waddr_q, waddr_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic xfer, last_xfer, sck_rise, cs_fall, cs_rise, err_evt;

  always_comb begin
    state_d    = state_q;
    sck_prev_d = sck_s;
    cs_prev_d  = cs_s;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    wpix_d     = wpix_q;
    waddr_d    = waddr_q;
    wr_valid_d = wr_valid_q;
    err_evt    = 1'b0;

    xfer      = wr_valid_q & wr.wr_ready;
    last_xfer = xfer && (waddr_q == ADDR_MAX);
    sck_rise  = sck_s & ~sck_prev_q;
    cs_fall   = ~cs_s & cs_prev_q;
    cs_rise   = cs_s & ~cs_prev_q;

    // A pending pixel keeps draining regardless of frame state.
    if (xfer) begin
      wr_valid_d = 1'b0;
      waddr_d    = waddr_q + FRAME_ORDER'(1);
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d  = RECV;
          bitcnt_d = '0;
          waddr_d  = '0;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_d  = IDLE;
          bitcnt_d = '0;
          err_evt  = !last_xfer;
        end else if (last_xfer) begin
          state_d = FULL;
        end else if (sck_rise && !cs_s) begin
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            // Overrun: the held pixel wins, the new one is lost.
            if (wr_valid_q && !xfer) begin
              err_evt = 1'b1;
            end else begin
              wpix_d     = {sdi_s, shreg_q};
              wr_valid_d = 1'b1;
            end
          end else begin
            shreg_d  = (W > 2) ? {sdi_s, shreg_q[W-2:1]} : W'(sdi_s);
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
      FULL: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    frame_err_d = ERR_EN & err_evt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      wpix_q      <= '0;
      waddr_q     <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      wpix_q      <= wpix_d;
      waddr_q     <= waddr_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.waddr    = waddr_q;
  assign wr.wpix     = wpix_q;
  assign frame_done  = last_xfer && (state_q == RECV);
  assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_pixel_rx.sv
// tb/tb_spi_pixel_rx.sv - self-checking bench for spi_pixel_rx (default 12-bit pixels, 1024-pixel frames).
`timescale 1ns/1ps
module tb_spi_pixel_rx;

`ifdef SPI_RX_ERR_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif

  typedef struct {
    logic [11:0] sent;     // bit 11 goes out first
    logic [11:0] exp_pix;
  } vec_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [11:0] pix;
  } xfer_t;

  logic clk = 1'b0;
  logic reset, sck, sdi, cs_n;
  logic frame_done, frame_err;
  logic rdy_fixed, rdy_rand, rand_rdy;
  logic in_full;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int full_valid_cnt = 0;
  int next_addr = 0;

  xfer_t expq[$];
  xfer_t mon_e;
  vec_t  tbl[5];

  spi_pixel_rx_if #(.CDEPTH(4), .FRAME_ORDER(10)) wif ();

  spi_pixel_rx dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .wr(wif), .frame_done(frame_done), .frame_err(frame_err)
  );

  assign wif.wr_ready = rand_rdy ? rdy_rand : rdy_fixed;

  always #12.5 clk = ~clk;

  always @(posedge clk) rdy_rand <= 1'($urandom_range(0, 1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted pixel must match the oldest expected one.
  always @(negedge clk) begin
    if (reset) begin
      if (wif.wr_valid && wif.wr_ready) begin
        if (expq.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("FAIL unexpected_xfer: got addr %0h pix %0h expected none", wif.waddr, wif.wpix);
        end else begin
          mon_e = expq.pop_front();
          chk("xfer_addr", 32'(wif.waddr), 32'(mon_e.addr));
          chk("xfer_pix", 32'(wif.wpix), 32'(mon_e.pix));
        end
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_addr", 32'(wif.waddr), 32'd1023);
        chk("done_xfer", 32'(wif.wr_valid & wif.wr_ready), 32'd1);
      end
      if (frame_err) err_cnt++;
      if (in_full && wif.wr_valid) full_valid_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    cyc(2);
    sck = 1'b1;
    cyc(2);
    sck = 1'b0;
  endtask

  task automatic send_pix(input logic [11:0] v);
    for (int k = 0; k < 12; k++) send_bit(v[k]);
  endtask

  task automatic send_seq(input logic [11:0] s);
    for (int k = 11; k >= 0; k--) send_bit(s[k]);
  endtask

  task automatic push_exp(input logic [11:0] p);
    expq.push_back({10'(next_addr), p});
    next_addr = (next_addr + 1) % 1024;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    next_addr = 0;
    cyc(4);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    cyc(8);
  endtask

  initial begin
    int e0, d0;
    logic [11:0] p1, p2, p3;

    tbl[0] = '{sent: 12'h800, exp_pix: 12'h001};
    tbl[1] = '{sent: 12'hABC, exp_pix: 12'h3D5};
    tbl[2] = '{sent: 12'hF00, exp_pix: 12'h00F};
    tbl[3] = '{sent: 12'h001, exp_pix: 12'h800};
    tbl[4] = '{sent: 12'h5A5, exp_pix: 12'hA5A};

    reset = 1'b0; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;
    rdy_fixed = 1'b1; rand_rdy = 1'b0; in_full = 1'b0;
    cyc(3);
    chk("rst_wr_valid", 32'(wif.wr_valid), 0);
    chk("rst_waddr", 32'(wif.waddr), 0);
    chk("rst_wpix", 32'(wif.wpix), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    reset = 1'b1;
    cyc(3);

    // Table vectors, then a short frame: 5 pixels and 7 bits.
    cs_low();
    for (int i = 0; i < 5; i++) begin
      push_exp(tbl[i].exp_pix);
      send_seq(tbl[i].sent);
    end
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
    cyc(6);
    chk("tbl_all_xfer", 32'(expq.size()), 0);
    e0 = err_cnt;
    cs_high();
    chk("short_frame_err", 32'(err_cnt - e0), 32'(E));

    // Full frame of 12'hABC, then 3 extra pixels that must be ignored.
    cs_low();
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 1024; i++) begin
      push_exp(12'hABC);
      send_pix(12'hABC);
    end
    cyc(10);
    chk("frame_all_xfer", 32'(expq.size()), 0);
    chk("frame_done_once", 32'(done_cnt - d0), 1);
    in_full = 1'b1;
    for (int i = 0; i < 3; i++) send_pix(12'($urandom));
    cyc(10);
    in_full = 1'b0;
    chk("full_no_valid", 32'(full_valid_cnt), 0);
    cs_high();
    chk("full_no_err", 32'(err_cnt - e0), 0);
    chk("full_done_total", 32'(done_cnt - d0), 1);

    // Overrun: ready held low across two pixel times.
    cs_low();
    e0 = err_cnt;
    rdy_fixed = 1'b0;
    p1 = 12'($urandom);
    p2 = ~p1;
    push_exp(p1);
    send_pix(p1);
    cyc(6);
    chk("ovr_valid_first", 32'(wif.wr_valid), 1);
    send_pix(p2);
    cyc(6);
    chk("ovr_hold_pix", 32'(wif.wpix), 32'(p1));
    chk("ovr_hold_addr", 32'(wif.waddr), 0);
    chk("ovr_hold_valid", 32'(wif.wr_valid), 1);
    chk("ovr_err", 32'(err_cnt - e0), 32'(E));
    rdy_fixed = 1'b1;
    cyc(4);
    chk("ovr_drain", 32'(expq.size()), 0);
    p3 = 12'($urandom);
    push_exp(p3);
    send_pix(p3);
    cyc(6);
    chk("ovr_next_addr", 32'(expq.size()), 0);
    cs_high();
    chk("ovr_err_total", 32'(err_cnt - e0), 32'(2 * E));

    // Random pixels with random downstream backpressure.
    cs_low();
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      p1 = 12'($urandom);
      push_exp(p1);
      send_pix(p1);
    end
    rand_rdy = 1'b0;
    cyc(10);
    chk("rand_all_xfer", 32'(expq.size()), 0);
    cs_high();

    // Reset mid-pixel with a held pixel outstanding.
    cs_low();
    push_exp(12'h123);
    send_pix(12'h123);
    push_exp(12'h456);
    send_pix(12'h456);
    cyc(4);
    rdy_fixed = 1'b0;
    push_exp(12'h789);
    send_pix(12'h789);
    cyc(4);
    chk("pre_rst_valid", 32'(wif.wr_valid), 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #3;
    reset = 1'b0;
    #2;
    chk("async_rst_valid", 32'(wif.wr_valid), 0);
    chk("async_rst_waddr", 32'(wif.waddr), 0);
    chk("async_rst_wpix", 32'(wif.wpix), 0);
    chk("async_rst_done", 32'(frame_done), 0);
    chk("async_rst_err", 32'(frame_err), 0);
    expq.delete();
    cs_n = 1'b1;
    rdy_fixed = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(3);
    cs_low();
    push_exp(12'hC3A);
    send_pix(12'hC3A);
    cyc(6);
    chk("post_rst_xfer", 32'(expq.size()), 0);
    cs_high();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
